// File: rtl/reg_readback.sv
// Debug readback engine: walks a register-file index range through a synchronous
// read port and streams {index, value} pairs out over a valid/ready handshake.
module reg_readback #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] first,
  input  logic [AW-1:0] last,
  output logic [AW-1:0] rf_raddr,
  input  logic [DW-1:0] rf_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_index,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [AW-1:0] MAX_IDX = AW'(NREGS - 1);

  logic [2:0]    state;
  logic [2:0]    state_next;
  logic [AW-1:0] idx;
  logic [AW-1:0] idx_next;
  logic [AW-1:0] last_idx;
  logic [AW-1:0] last_idx_next;
  logic [AW-1:0] raddr_next;
  logic          valid_next;
  logic [DW-1:0] data_next;
  logic [AW-1:0] index_next;
  logic          busy_next;
  logic          done_next;
  logic          xfer;
  logic [AW-1:0] idx_inc;

  // Out-of-range indices are clamped to the top entry when latched.
  function automatic logic [AW-1:0] clamp_idx(input logic [AW-1:0] v);
    return (v > MAX_IDX) ? MAX_IDX : v;
  endfunction

  assign xfer    = out_valid & out_ready;
  assign idx_inc = (idx == MAX_IDX) ? '0 : idx + AW'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_next    = state;
    idx_next      = idx;
    last_idx_next = last_idx;
    raddr_next    = rf_raddr;
    valid_next    = out_valid;
    data_next     = out_data;
    index_next    = out_index;
    done_next     = 1'b0;

    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_next    = S_ADDR;
          idx_next      = clamp_idx(first);
          last_idx_next = clamp_idx(last);
          raddr_next    = clamp_idx(first);
        end
      end
      S_ADDR: begin
        state_next = S_WAIT;
      end
      S_WAIT: begin
        state_next = S_SEND;
        data_next  = rf_rdata;
        index_next = idx;
        valid_next = 1'b1;
      end
      S_SEND: begin
        if (xfer) begin
          valid_next = 1'b0;
          if (idx == last_idx) begin
            state_next = S_DONE;
            done_next  = 1'b1;
          end else begin
            state_next = S_ADDR;
            idx_next   = idx_inc;
            raddr_next = idx_inc;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Abort outranks a simultaneous transfer and suppresses the done pulse.
    if (abort && (state != S_IDLE)) begin
      state_next = S_IDLE;
      valid_next = 1'b0;
      done_next  = 1'b0;
    end

    busy_next = (state_next != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      last_idx  <= '0;
      rf_raddr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      last_idx  <= last_idx_next;
      rf_raddr  <= raddr_next;
      out_valid <= valid_next;
      out_data  <= data_next;
      out_index <= index_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

endmodule

// File: tb/tb_reg_readback.sv
// Bench for reg_readback: a behavioural register file plus a range/ordering model
// of the expected word stream, with per-scenario checking tasks.
module tb_reg_readback;

  localparam int NR = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  first = '0;
  logic [4:0]  last = '0;
  logic        out_ready = 1'b0;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_index;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [31:0] rf_mem [NR];

  logic [4:0]  q_idx [$];
  logic [31:0] q_dat [$];
  int          q_cyc [$];
  int          done_cnt;
  int          done_at;
  int          start_at;
  int          stable_err;
  bit          timeout;
  logic        busy_post;
  logic        busy_at_done;

  reg_readback #(.NREGS(32), .AW(5), .DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .first     (first),
    .last      (last),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rf_rdata <= rf_mem[rf_raddr];

  function automatic int exp_count(input int f, input int l);
    return ((l - f + NR) % NR) + 1;
  endfunction

  function automatic int exp_idx(input int f, input int k);
    return (f + k) % NR;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [4:0] f, input logic [4:0] l);
    first    = f;
    last     = l;
    start    = 1'b1;
    start_at = cyc;
    tick();
    start = 1'b0;
  endtask

  // Drives out_ready and records every transfer until one cycle past done.
  task automatic collect(input int stall, input bit rnd, input int maxcyc);
    int          waited = 0;
    int          wcnt = 0;
    bit          held = 0;
    bit          seen_done = 0;
    logic [4:0]  h_idx = '0;
    logic [31:0] h_dat = '0;
    q_idx.delete();
    q_dat.delete();
    q_cyc.delete();
    done_cnt   = 0;
    done_at    = -1;
    stable_err = 0;
    timeout    = 0;
    while (1) begin
      if (seen_done) begin
        busy_post = busy;
        if (done) done_cnt++;
        break;
      end
      if (done) begin
        done_cnt++;
        done_at      = cyc;
        busy_at_done = busy;
        seen_done    = 1;
      end
      if (out_valid && held && (out_index !== h_idx || out_data !== h_dat)) stable_err++;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      else     out_ready = (out_valid && wcnt < stall) ? 1'b0 : 1'b1;
      if (out_valid && out_ready) begin
        q_idx.push_back(out_index);
        q_dat.push_back(out_data);
        q_cyc.push_back(cyc);
        held = 0;
        wcnt = 0;
      end else if (out_valid) begin
        held  = 1;
        h_idx = out_index;
        h_dat = out_data;
        wcnt++;
      end else begin
        held = 0;
      end
      if (waited >= maxcyc) begin
        timeout = 1;
        break;
      end
      waited++;
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({rf_raddr, out_valid, out_data, out_index, busy, done} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %0h expected 0",
               {rf_raddr, out_valid, out_data, out_index, busy, done});
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%b valid=%b expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_full_scan();
    do_start(5'd0, 5'd31);
    tests++;
    if (busy !== 1'b1 || rf_raddr !== 5'd0) begin
      fails++;
      $display("FAIL full_t1: busy=%b raddr=%0d expected 1 0", busy, rf_raddr);
    end
    collect(0, 0, 300);
    tests++;
    if (timeout || q_idx.size() != 32) begin
      fails++;
      $display("FAIL full_count: got %0d words timeout=%0d expected 32", q_idx.size(), timeout);
    end
    for (int k = 0; k < q_idx.size() && k < 32; k++) begin
      tests++;
      if (q_idx[k] !== 5'(exp_idx(0, k)) || q_dat[k] !== rf_mem[exp_idx(0, k)]
          || q_cyc[k] != start_at + 3 + 3 * k) begin
        fails++;
        $display("FAIL full_word%0d: got idx=%0d data=%h cyc=%0d expected idx=%0d data=%h cyc=%0d",
                 k, q_idx[k], q_dat[k], q_cyc[k] - start_at, exp_idx(0, k),
                 rf_mem[exp_idx(0, k)], 3 + 3 * k);
      end
    end
    tests++;
    if (done_at != start_at + 97 || done_cnt != 1 || busy_at_done !== 1'b1) begin
      fails++;
      $display("FAIL full_done: got at=%0d cnt=%0d busy=%b expected at=97 cnt=1 busy=1",
               done_at - start_at, done_cnt, busy_at_done);
    end
    tests++;
    if (busy_post !== 1'b0) begin
      fails++;
      $display("FAIL full_busy_low: got %b expected 0", busy_post);
    end
  endtask

  task automatic test_backpressure();
    do_start(5'd4, 5'd6);
    collect(5, 0, 300);
    tests++;
    if (timeout || q_idx.size() != 3 || done_cnt != 1) begin
      fails++;
      $display("FAIL bp_count: got words=%0d dones=%0d timeout=%0d expected 3 1 0",
               q_idx.size(), done_cnt, timeout);
    end
    for (int k = 0; k < q_idx.size() && k < 3; k++) begin
      tests++;
      if (q_idx[k] !== 5'(4 + k) || q_dat[k] !== rf_mem[4 + k]) begin
        fails++;
        $display("FAIL bp_word%0d: got %0d/%h expected %0d/%h",
                 k, q_idx[k], q_dat[k], 4 + k, rf_mem[4 + k]);
      end
    end
    tests++;
    if (stable_err != 0) begin
      fails++;
      $display("FAIL bp_stable: got %0d changes while stalled expected 0", stable_err);
    end
    tests++;
    if (q_cyc.size() < 2 || q_cyc[0] != start_at + 8 || q_cyc[1] - q_cyc[0] != 8) begin
      fails++;
      $display("FAIL bp_timing: got first=%0d expected 8 with spacing 8",
               (q_cyc.size() > 0) ? q_cyc[0] - start_at : -1);
    end
  endtask

  task automatic test_wrap();
    do_start(5'd30, 5'd1);
    collect(0, 0, 100);
    tests++;
    if (timeout || q_idx.size() != 4 || done_cnt != 1) begin
      fails++;
      $display("FAIL wrap_count: got words=%0d dones=%0d expected 4 1", q_idx.size(), done_cnt);
    end
    for (int k = 0; k < q_idx.size() && k < 4; k++) begin
      tests++;
      if (q_idx[k] !== 5'(exp_idx(30, k)) || q_dat[k] !== rf_mem[exp_idx(30, k)]) begin
        fails++;
        $display("FAIL wrap_word%0d: got %0d/%h expected %0d/%h",
                 k, q_idx[k], q_dat[k], exp_idx(30, k), rf_mem[exp_idx(30, k)]);
      end
    end
  endtask

  task automatic test_single();
    rf_mem[5] = 32'hDEAD_BEEF;
    do_start(5'd5, 5'd5);
    tick();
    first = 5'd9;
    last  = 5'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_index !== 5'd5 || out_data !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL single_word: got v=%b %0d/%h expected 1 5/deadbeef",
               out_valid, out_index, out_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_done: got done=%b valid=%b busy=%b expected 1 0 1",
               done, out_valid, busy);
    end
    tick();
    tick();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL single_ignored_start: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_abort();
    int extra_done = 0;
    do_start(5'd0, 5'd31);
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    tick();
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_index !== 5'd1) begin
      fails++;
      $display("FAIL abort_pre: got v=%b idx=%0d expected 1 1", out_valid, out_index);
    end
    abort = 1'b1;
    tick();
    abort     = 1'b0;
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: got v=%b busy=%b done=%b expected 0 0 0",
               out_valid, busy, done);
    end
    for (int i = 0; i < 5; i++) begin
      if (done === 1'b1 || busy === 1'b1) extra_done++;
      tick();
    end
    tests++;
    if (extra_done != 0) begin
      fails++;
      $display("FAIL abort_quiet: got %0d active cycles expected 0", extra_done);
    end
    first = 5'd3;
    last  = 5'd3;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_start_together: got busy=%b expected 0", busy);
    end
    do_start(5'd7, 5'd7);
    collect(0, 0, 50);
    tests++;
    if (timeout || q_idx.size() != 1 || q_idx[0] !== 5'd7 || q_dat[0] !== rf_mem[7]) begin
      fails++;
      $display("FAIL abort_restart: got words=%0d expected one word 7/%h", q_idx.size(), rf_mem[7]);
    end
  endtask

  task automatic test_async_reset();
    do_start(5'd2, 5'd9);
    tick();
    #3 rst = 1'b1;
    #1;
    tests++;
    if ({rf_raddr, out_valid, out_data, out_index, busy, done} !== '0) begin
      fails++;
      $display("FAIL async_reset: got %0h expected 0",
               {rf_raddr, out_valid, out_data, out_index, busy, done});
    end
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    rf_mem[0] = $urandom;
    do_start(5'd0, 5'd0);
    collect(0, 0, 50);
    tests++;
    if (timeout || q_idx.size() != 1 || q_idx[0] !== 5'd0 || q_dat[0] !== rf_mem[0]
        || q_cyc[0] != start_at + 3 || done_at != q_cyc[0] + 1 || busy_post !== 1'b0) begin
      fails++;
      $display("FAIL async_rescan: got words=%0d done_at=%0d expected one word %h at 3, done at 4",
               q_idx.size(), done_at - start_at, rf_mem[0]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int f = $urandom_range(0, NR - 1);
      int l = $urandom_range(0, NR - 1);
      int n = exp_count(f, l);
      for (int i = 0; i < NR; i++) rf_mem[i] = $urandom;
      do_start(5'(f), 5'(l));
      collect(0, 1, 3000);
      tests++;
      if (timeout || q_idx.size() != n || done_cnt != 1 || stable_err != 0) begin
        fails++;
        $display("FAIL rand%0d_count: got words=%0d dones=%0d unstable=%0d expected %0d 1 0 (f=%0d l=%0d)",
                 it, q_idx.size(), done_cnt, stable_err, n, f, l);
      end
      for (int k = 0; k < q_idx.size() && k < n; k++) begin
        tests++;
        if (q_idx[k] !== 5'(exp_idx(f, k)) || q_dat[k] !== rf_mem[exp_idx(f, k)]) begin
          fails++;
          $display("FAIL rand%0d_word%0d: got %0d/%h expected %0d/%h",
                   it, k, q_idx[k], q_dat[k], exp_idx(f, k), rf_mem[exp_idx(f, k)]);
        end
      end
      tests++;
      if (q_cyc.size() == 0 || done_at != q_cyc[q_cyc.size() - 1] + 1) begin
        fails++;
        $display("FAIL rand%0d_done: got done_at=%0d expected one cycle after final transfer", it, done_at);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) rf_mem[i] = 32'h1000_0000 + 32'(i);
    test_reset();
    test_full_scan();
    test_backpressure();
    test_wrap();
    test_single();
    test_abort();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
